// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - shares one Wishbone classic slave between instr and data masters
// Define WB_ARB_RR_EN for round-robin on simultaneous requests; default is fixed data priority.
module wishbone_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   i_adr,
  input  logic [XLEN/8-1:0] i_sel,
  input  logic              i_we,
  input  logic              i_stb,
  input  logic              i_cyc,
  input  logic [XLEN-1:0]   i_dat_w,
  output logic [XLEN-1:0]   i_dat_r,
  output logic              i_ack,
  input  logic [XLEN-1:0]   d_adr,
  input  logic [XLEN/8-1:0] d_sel,
  input  logic              d_we,
  input  logic              d_stb,
  input  logic              d_cyc,
  input  logic [XLEN-1:0]   d_dat_w,
  output logic [XLEN-1:0]   d_dat_r,
  output logic              d_ack,
  output logic [XLEN-1:0]   s_adr,
  output logic [XLEN/8-1:0] s_sel,
  output logic              s_we,
  output logic              s_stb,
  output logic              s_cyc,
  output logic [XLEN-1:0]   s_dat_w,
  input  logic [XLEN-1:0]   s_dat_r,
  input  logic              s_ack
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] BEAT_MAX   = CW'(MAX_BEATS);
  localparam logic [CW-1:0] BEAT_LIMIT = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] beats, beats_nxt;
  logic          last_d, last_d_nxt;
  logic          req_i, req_d, beat, at_limit;

  assign req_i    = i_cyc & i_stb;
  assign req_d    = d_cyc & d_stb;
  assign beat     = s_ack & s_stb;
  // >= rather than == so a saturated counter still yields to a late requester
  assign at_limit = (beats >= BEAT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beats  <= '0;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      beats  <= beats_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
`ifdef WB_ARB_RR_EN
          state_nxt = last_d ? GNT_I : GNT_D;
`else
          state_nxt = GNT_D;
`endif
        end else if (req_d) begin
          state_nxt = GNT_D;
        end else if (req_i) begin
          state_nxt = GNT_I;
        end
      end
      // A stalled beat (stb high, no ack) never matches either branch, so the grant holds
      GNT_I: begin
        if (!i_cyc)                         state_nxt = req_d ? GNT_D : IDLE;
        else if (beat && at_limit && req_d) state_nxt = GNT_D;
      end
      GNT_D: begin
        if (!d_cyc)                         state_nxt = req_i ? GNT_I : IDLE;
        else if (beat && at_limit && req_i) state_nxt = GNT_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beats_nxt  = beats;
    last_d_nxt = last_d;
    if (state_nxt != state || state_nxt == IDLE) begin
      beats_nxt = '0;
    end else if (beat && beats != BEAT_MAX) begin
      beats_nxt = beats + CW'(1);
    end
    if (state_nxt != state) begin
      if (state_nxt == GNT_D)      last_d_nxt = 1'b1;
      else if (state_nxt == GNT_I) last_d_nxt = 1'b0;
    end
  end

  always_comb begin
    s_adr   = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    s_dat_w = '0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    case (state)
      GNT_I: begin
        s_adr   = i_adr;
        s_sel   = i_sel;
        s_we    = i_we;
        s_stb   = i_stb;
        s_cyc   = i_cyc;
        s_dat_w = i_dat_w;
        i_ack   = s_ack;
      end
      GNT_D: begin
        s_adr   = d_adr;
        s_sel   = d_sel;
        s_we    = d_we;
        s_stb   = d_stb;
        s_cyc   = d_cyc;
        s_dat_w = d_dat_w;
        d_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign i_dat_r = s_dat_r;
  assign d_dat_r = s_dat_r;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - directed self-checking bench for wishbone_arbiter
// Follows WB_ARB_RR_EN to pick the expected winner of simultaneous requests.
module tb_wishbone_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_adr, i_dat_w, i_dat_r, d_adr, d_dat_w, d_dat_r, s_adr, s_dat_w, s_dat_r;
  logic [3:0]  i_sel, d_sel, s_sel;
  logic        i_we, i_stb, i_cyc, i_ack, d_we, d_stb, d_cyc, d_ack;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic        ack_force, ack_auto;
  int          checks = 0;
  int          errors = 0;

`ifdef WB_ARB_RR_EN
  localparam logic FIRST_D = 1'b0;
`else
  localparam logic FIRST_D = 1'b1;
`endif

  always #5 clk = ~clk;

  // Zero-wait slave when ack_auto is set; ack_force drives ACK regardless of bus state
  assign s_ack = ack_force | (ack_auto & s_cyc & s_stb);

  wishbone_arbiter #(.XLEN(32), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr(i_adr), .i_sel(i_sel), .i_we(i_we), .i_stb(i_stb), .i_cyc(i_cyc),
    .i_dat_w(i_dat_w), .i_dat_r(i_dat_r), .i_ack(i_ack),
    .d_adr(d_adr), .d_sel(d_sel), .d_we(d_we), .d_stb(d_stb), .d_cyc(d_cyc),
    .d_dat_w(d_dat_w), .d_dat_r(d_dat_r), .d_ack(d_ack),
    .s_adr(s_adr), .s_sel(s_sel), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_adr = 32'h0; i_sel = 4'hf; i_we = 1'b0; i_dat_w = 32'h0; i_cyc = 1'b1; i_stb = 1'b1;
    d_adr = 32'h0; d_sel = 4'hf; d_we = 1'b0; d_dat_w = 32'h0; d_cyc = 1'b0; d_stb = 1'b0;
    s_dat_r = 32'h0; ack_force = 1'b1; ack_auto = 1'b0;

    // Reset holds outputs low with no clock edge seen yet
    #3;
    chk("rst_async_s_cyc", s_cyc, 0);
    chk("rst_async_s_stb", s_stb, 0);
    chk("rst_async_i_ack", i_ack, 0);
    chk("rst_async_d_ack", d_ack, 0);
    tick(); tick();
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_i_ack", i_ack, 0);
    i_cyc = 1'b0; i_stb = 1'b0; ack_force = 1'b0;
    rst_n = 1'b1;
    tick();

    // Simultaneous requests from IDLE, last owner DATA after reset
    ack_auto = 1'b1;
    i_adr = 32'h100; d_adr = 32'h200;
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
    #1;
    chk("both_pre_grant_s_stb", s_stb, 0);
    tick();
    chk("both_first_adr", s_adr, FIRST_D ? 32'h200 : 32'h100);
    chk("both_first_d_ack", d_ack, FIRST_D);
    chk("both_first_i_ack", i_ack, !FIRST_D);
    tick();
    if (FIRST_D) begin d_cyc = 1'b0; d_stb = 1'b0; end
    else         begin i_cyc = 1'b0; i_stb = 1'b0; end
    #1;
    chk("both_drop_s_cyc", s_cyc, 0);
    tick();
    chk("both_second_adr", s_adr, FIRST_D ? 32'h100 : 32'h200);
    chk("both_second_s_stb", s_stb, 1);
    chk("both_second_i_ack", i_ack, FIRST_D);
    tick();
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    tick();
    chk("both_idle_s_cyc", s_cyc, 0);

    // Single instr read with one-cycle slave latency
    ack_auto = 1'b0;
    i_adr = 32'h100; i_cyc = 1'b1; i_stb = 1'b1;
    #1;
    chk("rd_pre_grant_s_stb", s_stb, 0);
    tick();
    chk("rd_s_adr", s_adr, 32'h100);
    chk("rd_s_stb", s_stb, 1);
    chk("rd_wait_i_ack", i_ack, 0);
    ack_force = 1'b1; s_dat_r = 32'hdeadbeef;
    #1;
    chk("rd_i_ack", i_ack, 1);
    chk("rd_i_dat_r", i_dat_r, 32'hdeadbeef);
    chk("rd_d_dat_r", d_dat_r, 32'hdeadbeef);
    chk("rd_d_ack", d_ack, 0);
    tick();
    ack_force = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
    #1;
    chk("rd_drop_s_cyc", s_cyc, 0);
    tick();

    // Spurious slave ACK in IDLE
    ack_force = 1'b1;
    #1;
    chk("spur_i_ack", i_ack, 0);
    chk("spur_d_ack", d_ack, 0);
    tick();
    ack_force = 1'b0;

    // Instr burst of 20 beats, data joins at beat 2, preempted after beat 8
    ack_auto = 1'b1;
    i_adr = 32'h400; d_adr = 32'h800;
    i_cyc = 1'b1; i_stb = 1'b1;
    tick();
    for (int b = 1; b <= 8; b++) begin
      chk($sformatf("burst_i_ack_beat%0d", b), i_ack, 1);
      chk($sformatf("burst_d_ack_beat%0d", b), d_ack, 0);
      if (b == 2) begin d_cyc = 1'b1; d_stb = 1'b1; end
      tick();
    end
    chk("preempt_s_adr", s_adr, 32'h800);
    chk("preempt_d_ack", d_ack, 1);
    chk("preempt_i_ack", i_ack, 0);
    tick();
    d_cyc = 1'b0; d_stb = 1'b0;
    #1;
    chk("preempt_drop_s_stb", s_stb, 0);
    chk("preempt_drop_d_ack", d_ack, 0);
    tick();
    chk("resume_s_adr", s_adr, 32'h400);
    chk("resume_i_ack", i_ack, 1);
    for (int b = 10; b <= 20; b++) begin
      tick();
      chk($sformatf("burst_i_ack_beat%0d", b), i_ack, 1);
    end
    tick();
    i_cyc = 1'b0; i_stb = 1'b0;
    #1;
    chk("burst_end_i_ack", i_ack, 0);
    tick();

    // Data write with a 5-cycle slave stall while instr waits
    ack_auto = 1'b0;
    d_adr = 32'h300; d_we = 1'b1; d_sel = 4'b0011; d_dat_w = 32'h12345678;
    d_cyc = 1'b1; d_stb = 1'b1;
    tick();
    i_adr = 32'h500; i_cyc = 1'b1; i_stb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_s_we", c), s_we, 1);
      chk($sformatf("stall%0d_s_sel", c), s_sel, 4'b0011);
      chk($sformatf("stall%0d_s_adr", c), s_adr, 32'h300);
      chk($sformatf("stall%0d_d_ack", c), d_ack, 0);
      chk($sformatf("stall%0d_i_ack", c), i_ack, 0);
      tick();
    end
    ack_force = 1'b1;
    #1;
    chk("stall_end_d_ack", d_ack, 1);
    chk("stall_end_s_dat_w", s_dat_w, 32'h12345678);
    tick();
    ack_force = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
    #1;
    chk("stall_drop_d_ack", d_ack, 0);
    tick();
    chk("stall_next_s_adr", s_adr, 32'h500);
    chk("stall_next_s_we", s_we, 0);
    i_cyc = 1'b0; i_stb = 1'b0;
    tick(); tick();

    // Async reset while data owns the bus and the slave stalls
    d_adr = 32'h600; d_cyc = 1'b1; d_stb = 1'b1;
    tick();
    chk("midrst_pre_s_stb", s_stb, 1);
    #2;
    rst_n = 1'b0; ack_force = 1'b1;
    #1;
    chk("midrst_s_cyc", s_cyc, 0);
    chk("midrst_s_stb", s_stb, 0);
    chk("midrst_s_adr", s_adr, 0);
    chk("midrst_d_ack", d_ack, 0);
    d_cyc = 1'b0; d_stb = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("postrst_d_ack", d_ack, 0);
    chk("postrst_i_ack", i_ack, 0);
    chk("postrst_s_cyc", s_cyc, 0);
    ack_force = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
